// File: rtl/operand_sequencer.sv
// Operand sequencer: issues a walking a operand with a fixed b operand
// downstream and captures the returned results into a small buffer.
module operand_sequencer #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [W-1:0]             a_first,
  input  logic [W-1:0]             a_last,
  input  logic [W-1:0]             b_value,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b,
  output logic                     op_valid,
  input  logic                     op_ready,
  input  logic [W-1:0]             out,
  input  logic                     out_valid,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [W:0]               count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [W:0]   n;
  logic [W:0]   issued;
  logic [W:0]   count_nx;
  logic         active;
  logic         xfer;
  logic         last_xfer;
  logic         cap;
  logic         fin;
  logic [W-1:0] mem [DEPTH];

  assign active    = (state == ISSUE) || (state == DRAIN);
  assign op_valid  = (state == ISSUE);
  assign busy      = active;
  assign done      = (state == DONE);
  assign xfer      = op_valid && op_ready;
  assign last_xfer = xfer && (issued == n - 1'b1);
  assign cap       = active && out_valid && (count < n);
  assign count_nx  = count + {{W{1'b0}}, cap};
  assign fin       = (count_nx == n);
  assign rd_data   = mem[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      n        <= '0;
      issued   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // a result with no slot left, or outside a sequence, is dropped
      if (out_valid && !cap) overflow <= 1'b1;
      count <= count_nx;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a        <= a_first;
            b        <= b_value;
            n        <= {1'b0, a_last - a_first} + 1'b1;
            issued   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            a      <= a + 1'b1;
            issued <= issued + 1'b1;
            if (last_xfer) state <= fin ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (fin) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem[count[AW-1:0]] <= out;
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: operand and result
// expectations are queued at start and popped as the DUT responds.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a_first = '0;
  logic [3:0] a_last = '0;
  logic [3:0] b_value = '0;
  logic [3:0] a;
  logic [3:0] b;
  logic       op_valid;
  logic       op_ready = 1'b0;
  logic [3:0] out = '0;
  logic       out_valid = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic       overflow;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] exp_a [$];
  logic [3:0] exp_r [$];

  operand_sequencer #(.W(4), .DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_first  (a_first),
    .a_last   (a_last),
    .b_value  (b_value),
    .a        (a),
    .b        (b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .out      (out),
    .out_valid(out_valid),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_b"}, b, 0);
    chk({tag, "_opv"}, op_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, count, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic run_seq(input logic [3:0] af, input logic [3:0] al,
                         input logic [3:0] bv, input int lat,
                         input int stall_at, input int stall_len,
                         input bit poke, input int rst_after);
    int n;
    int xfers;
    bit rdy;
    bit pv;
    logic [3:0] pd;
    logic [3:0] ea;
    n = int'(4'(al - af)) + 1;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(4'(af + 4'(i)));
      exp_r.push_back(4'(af + 4'(i)));
    end
    a_first = af;
    a_last  = al;
    b_value = bv;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy, 1);
    xfers = 0;
    pv = 1'b0;
    pd = '0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (rst_after >= 0 && xfers == rst_after) begin
        op_ready  = 1'b0;
        out_valid = 1'b0;
        #1 reset = 1'b1;
        #1 chk_zero("rst_mid");
        reset = 1'b0;
        exp_a.delete();
        exp_r.delete();
        @(negedge clk);
        return;
      end
      rdy = !(cyc >= stall_at && cyc < stall_at + stall_len);
      start = poke && (cyc == 2);
      if (!rdy) begin
        chk("hold_v", op_valid, 1);
        chk("hold_b", b, bv);
        if (exp_a.size() > 0) chk("hold_a", a, exp_a[0]);
      end
      op_ready  = rdy;
      out_valid = 1'b0;
      if (lat == 1) begin
        out_valid = pv;
        out       = pd;
        pv        = 1'b0;
      end
      if (op_valid && rdy) begin
        xfers++;
        if (exp_a.size() == 0) begin
          chk("extra_xfer", 1, 0);
        end else begin
          ea = exp_a.pop_front();
          chk("a", a, ea);
          chk("b", b, bv);
        end
        if (lat == 0) begin
          out_valid = 1'b1;
          out       = a;
        end else begin
          pv = 1'b1;
          pd = a;
        end
      end
      @(negedge clk);
    end
    start     = 1'b0;
    op_ready  = 1'b0;
    out_valid = 1'b0;
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("nxfer", xfers, n);
    chk("count", count, n);
    chk("ovf", overflow, 0);
    for (int i = 0; i < n; i++) begin
      rd_addr = 4'(i);
      #1 chk("buf", rd_data, exp_r.pop_front());
    end
    exp_a.delete();
    @(negedge clk);
  endtask

  initial begin
    #1 chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    run_seq(4'd1, 4'd9, 4'd10, 1, 100, 0, 1'b0, -1);
    run_seq(4'd14, 4'd1, 4'd3, 1, 100, 0, 1'b0, -1);
    run_seq(4'd2, 4'd11, 4'd6, 1, 3, 3, 1'b0, -1);
    run_seq(4'd5, 4'd5, 4'd9, 0, 100, 0, 1'b0, -1);
    run_seq(4'd0, 4'd15, 4'd4, 0, 5, 2, 1'b0, -1);
    run_seq(4'd3, 4'd8, 4'd1, 1, 100, 0, 1'b1, -1);

    out_valid = 1'b1;
    out       = 4'd7;
    @(negedge clk);
    out_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", count, 6);
    chk("ovf_done", done, 1);
    @(negedge clk);
    chk("ovf_sticky", overflow, 1);

    run_seq(4'd2, 4'd12, 4'd5, 1, 100, 0, 1'b0, 3);
    run_seq(4'd2, 4'd12, 4'd5, 1, 100, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter W, default 4, meaning operand/result width in bits.
REQ-002 Parameter DEPTH, default 16 (=2**W), meaning result capture buffer entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse launching a sequence; sampled only in IDLE or DONE.
REQ-006 a_first  input  W  first a operand; latched on accepted start.
REQ-007 a_last  input  W  last a operand; latched on accepted start.
REQ-008 b_value  input  W  constant b operand for whole sequence; latched on accepted start.
REQ-009 a  output  W  current a operand presented downstream.
REQ-010 b  output  W  current b operand presented downstream.
REQ-011 op_valid  output  1  a/b pair valid.
REQ-012 op_ready  input  1  downstream accepts pair; transfer when op_valid && op_ready.
REQ-013 out  input  W  result returned by downstream.
REQ-014 out_valid  input  1  out holds a result this cycle.
REQ-015 rd_addr  input  log2(DEPTH)  capture buffer read address.
REQ-016 rd_data  output  W  combinational read of buffer[rd_addr].
REQ-017 busy  output  1  high in ISSUE or DRAIN.
REQ-018 done  output  1  high in DONE.
REQ-019 count  output  W+1  results captured in current/last sequence.
REQ-020 overflow  output  1  sticky: unexpected result seen.

Function
REQ-021 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-022 IDLE/DONE + start: latch a_first/a_last/b_value, clear count, overflow, issue and write pointers; go ISSUE next cycle.
REQ-023 start in ISSUE or DRAIN ignored, no state change.
REQ-024 Sequence length N = ((a_last - a_first) mod 2**W) + 1, range 1..16; a_first > a_last wraps through 15 to 0 (e.g. 14,15,0,1).
REQ-025 ISSUE: op_valid=1, a=current operand, b=latched b_value; a/b held stable while op_valid && !op_ready.
REQ-026 On each transfer, a increments mod 2**W; after N-th transfer op_valid deasserts next cycle and FSM goes DRAIN.
REQ-027 Result capture active in ISSUE and DRAIN: each out_valid cycle with count < N writes out to buffer[count], count increments by 1.
REQ-028 out_valid with count == N, or in IDLE/DONE, sets overflow; not stored, count unchanged.
REQ-029 Same-cycle final transfer and result capture both take effect.
REQ-030 DRAIN -> DONE on the cycle count reaches N (may be same edge as ISSUE exit if all results arrived, going ISSUE -> DONE directly).
REQ-031 Zero-latency downstream (result same cycle as transfer) supported; results captured in arrival order.
REQ-032 Buffer contents persist through DONE and into IDLE until overwritten; start does not clear buffer.
REQ-033 No timeout; DRAIN waits indefinitely.

Reset
REQ-034 reset asserted: state IDLE, a=0, b=0, op_valid=0, busy=0, done=0, count=0, overflow=0, pointers=0, immediately without clock.
REQ-035 Reset mid-sequence abandons transfers; buffer contents undefined, not required cleared.
REQ-036 First start accepted on first rising edge after reset deasserts.

Verification
REQ-037 a_first=1, a_last=9, b_value=10, op_ready=1, downstream echoes a one cycle later -> nine transfers a=1..9, b=10; count=9; buffer[0..8]=1..9; done=1; overflow=0.
REQ-038 a_first=14, a_last=1, op_ready=1 -> a=14,15,0,1, N=4, done after 4 results.
REQ-039 op_ready low 3 cycles mid-sequence -> a/b/op_valid held stable; no skip/duplicate.
REQ-040 a_first=a_last=5 with result in same cycle as transfer -> N=1, ISSUE->DONE, count=1, buffer[0]=5.
REQ-041 Extra out_valid after count=N, and start pulsed during ISSUE -> overflow=1, count unchanged; start ignored.
REQ-042 reset asserted during ISSUE after 3 transfers -> outputs zero asynchronously; new start after release runs full sequence correctly.
